// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: sequences PLL reset, lock qualification and downstream core reset release.
module pll_reset_ctrl #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic [3:0] retry_cnt,
  output logic [1:0] status
);
  localparam int MAX_AB = RST_CYCLES > LOCK_STABLE ? RST_CYCLES : LOCK_STABLE;
  localparam int MAX_C  = MAX_AB > LOCK_TIMEOUT ? MAX_AB : LOCK_TIMEOUT;
  localparam int CW     = $clog2(MAX_C);
  typedef enum logic [1:0] {RESET_PLL, WAIT_LOCK, STABILIZE, RUN} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic meta, locked_s, inc;
  always_comb begin
    nxt = state;
    inc = 1'b0;
    case (state)
      RESET_PLL: nxt = cnt == CW'(RST_CYCLES - 1) ? WAIT_LOCK : RESET_PLL;
      WAIT_LOCK: begin
        nxt = relock_req ? RESET_PLL : locked_s ? STABILIZE :
              cnt == CW'(LOCK_TIMEOUT - 1) ? RESET_PLL : WAIT_LOCK;
        inc = !relock_req && !locked_s && cnt == CW'(LOCK_TIMEOUT - 1);
      end
      STABILIZE: nxt = relock_req ? RESET_PLL : !locked_s ? WAIT_LOCK :
                       cnt == CW'(LOCK_STABLE - 1) ? RUN : STABILIZE;
      RUN: begin
        nxt = relock_req || !locked_s ? RESET_PLL : RUN;
        inc = !relock_req && !locked_s;
      end
      default: nxt = RESET_PLL;
    endcase
  end
  // outputs are decoded from the next state so they change on the transition edge
  always_ff @(posedge refclk or posedge rst)
    if (rst) begin
      meta      <= 1'b0;
      locked_s  <= 1'b0;
      state     <= RESET_PLL;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      sys_reset <= 1'b1;
      retry_cnt <= '0;
    end else begin
      meta      <= pll_locked;
      locked_s  <= meta;
      state     <= nxt;
      cnt       <= nxt != state ? '0 : cnt + 1'b1;
      pll_rst   <= nxt == RESET_PLL;
      sys_reset <= nxt != RUN;
      if (inc && retry_cnt != 4'hf) retry_cnt <= retry_cnt + 1'b1;
    end
  assign status = state;
endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb_pll_reset_ctrl: directed scenarios plus random lock/relock/reset traffic checked against a cycle-count model.
module tb_pll_reset_ctrl;
  localparam int RC = 4, LS = 8, LT = 32;
  logic refclk = 1'b0, rst = 1'b1, pll_locked = 1'b0, relock_req = 1'b0;
  logic pll_rst, sys_reset;
  logic [3:0] retry_cnt;
  logic [1:0] status;
  int tests = 0, fails = 0;
  int m_phase = 0, m_el = 0, m_retry = 0;
  bit [1:0] d = 2'b00;

  pll_reset_ctrl #(.RST_CYCLES(RC), .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT)) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .relock_req(relock_req),
    .pll_rst(pll_rst), .sys_reset(sys_reset), .retry_cnt(retry_cnt), .status(status)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // returns next_phase*2 + retry_bump; spent = cycles in the phase including this one
  function automatic int step(int ph, int spent, bit ls, bit rq);
    if (ph != 0 && rq) return 0;
    case (ph)
      0: return spent == RC ? 2 : 0;
      1: return ls ? 4 : spent == LT ? 1 : 2;
      2: return !ls ? 2 : spent == LS ? 6 : 4;
      default: return !ls ? 1 : 6;
    endcase
  endfunction

  always @(posedge refclk or posedge rst)
    if (rst) begin
      m_phase <= 0;
      m_el    <= 0;
      m_retry <= 0;
      d       <= 2'b00;
    end else begin
      m_phase <= step(m_phase, m_el + 1, d[1], relock_req) / 2;
      m_el    <= step(m_phase, m_el + 1, d[1], relock_req) / 2 != m_phase ? 0 : m_el + 1;
      m_retry <= (step(m_phase, m_el + 1, d[1], relock_req) % 2 == 1 && m_retry < 15) ? m_retry + 1 : m_retry;
      d       <= {d[0], pll_locked};
    end

  always @(negedge refclk) begin
    chk("pll_rst", pll_rst, m_phase == 0);
    chk("sys_reset", sys_reset, m_phase != 3);
    chk("status", status, m_phase);
    chk("retry_cnt", retry_cnt, m_retry);
  end

  task automatic wait_status(input int v, input int lim, input string nm);
    for (int k = 0; k < lim; k++) begin
      @(negedge refclk);
      if (status == v) return;
    end
    chk(nm, status, v);
  endtask

  task automatic edges_until_release(output int n);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge refclk); #1;
      n++;
      if (!sys_reset) return;
    end
  endtask

  initial begin
    int w, n, nrise;
    int rise[$];
    logic prev;
    repeat (3) @(negedge refclk);
    chk("reset_pll_rst", pll_rst, 1);
    chk("reset_sys_reset", sys_reset, 1);
    chk("reset_status", status, 0);
    chk("reset_retry", retry_cnt, 0);
    rst = 1'b0;
    w = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge refclk);
      if (!pll_rst) break;
      w++;
    end
    chk("pwrup_pulse_width", w, 4);
    repeat (2) @(negedge refclk);
    pll_locked = 1'b1;
    edges_until_release(n);
    chk("pwrup_lock_to_release", n, 11);
    chk("pwrup_status", status, 3);
    chk("pwrup_retry", retry_cnt, 0);

    @(negedge refclk) relock_req = 1'b1;
    @(negedge refclk) relock_req = 1'b0;
    wait_status(2, 50, "glitch_reach_stab");
    repeat (5) @(negedge refclk);
    pll_locked = 1'b0;
    repeat (3) @(negedge refclk);
    chk("glitch_back_to_wait", status, 1);
    pll_locked = 1'b1;
    edges_until_release(n);
    chk("glitch_restart_release", n, 11);
    chk("glitch_retry", retry_cnt, 0);

    @(negedge refclk) pll_locked = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge refclk); #1;
      n++;
      if (pll_rst) break;
    end
    chk("loss_edges_to_pll_rst", n, 3);
    chk("loss_sys_reset", sys_reset, 1);
    chk("loss_retry", retry_cnt, 1);
    pll_locked = 1'b1;
    wait_status(3, 100, "loss_relock_run");

    @(negedge refclk) pll_locked = 1'b0;
    @(posedge refclk);
    @(posedge refclk);
    @(negedge refclk) relock_req = 1'b1;
    @(negedge refclk) relock_req = 1'b0;
    chk("relock_enter_reset", pll_rst, 1);
    w = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge refclk);
      if (!pll_rst) break;
      w++;
      relock_req = (i == 0);
    end
    relock_req = 1'b0;
    chk("relock_pulse_width", w, 4);
    chk("relock_retry", retry_cnt, 1);

    @(negedge refclk) rst = 1'b1;
    @(negedge refclk) rst = 1'b0;
    prev = 1'b1;
    for (int c = 0; c < 620; c++) begin
      @(negedge refclk);
      if (pll_rst && !prev) rise.push_back(c);
      prev = pll_rst;
    end
    nrise = rise.size();
    chk("timeout_rise_count", nrise, 17);
    if (nrise >= 4)
      for (int i = 1; i < 4; i++) chk("timeout_period", rise[i] - rise[i-1], 36);
    chk("timeout_retry_sat", retry_cnt, 15);

    pll_locked = 1'b1;
    wait_status(2, 100, "async_reach_stab");
    #2 rst = 1'b1;
    #1;
    chk("async_pll_rst", pll_rst, 1);
    chk("async_sys_reset", sys_reset, 1);
    chk("async_status", status, 0);
    chk("async_retry", retry_cnt, 0);
    @(negedge refclk) rst = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      @(negedge refclk);
      if ($urandom_range(0, 24) == 0) pll_locked = ~pll_locked;
      relock_req = $urandom_range(0, 39) == 0;
      rst = $urandom_range(0, 399) == 0;
    end
    @(negedge refclk);
    rst = 1'b0;
    relock_req = 1'b0;
    @(negedge refclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
